data_mem_if: RTL and testbench

- Sits between the main control unit and the single-port synchronous data SRAM.
- Turns the control unit's load/store handshake into SRAM read/write cycles:
  - byte-lane enables and store-data alignment for SB/SH/SW;
  - byte/halfword extraction with sign or zero extension for LB/LH/LW/LBU/LHU;
  - a `Misaligned` flag instead of a memory access for illegal alignment or an unsupported funct3.
- Its `Load_Valid` and `Store_Ready` outputs drive the control unit's data-memory valid/ready inputs directly.

---
 rtl/data_mem_if.sv | 139 +++++++++++++
 tb/tb_data_mem_if.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_if.sv
// Load/store bridge between the core's data-memory handshake and a single-port
// synchronous SRAM: lane enables, store alignment, load extraction, misalignment.
module data_mem_if #(
  parameter int ADDR_W      = 10,
  parameter int MEM_LATENCY = 1
) (
  input  logic              DMI_Clk,
  input  logic              DMI_Reset,
  input  logic              DMI_Load_Req,
  input  logic              DMI_Store_Req,
  input  logic [2:0]        DMI_Funct3,
  input  logic [31:0]       DMI_Address,
  input  logic [31:0]       DMI_Store_Data,
  output logic              DMI_Load_Valid,
  output logic              DMI_Store_Ready,
  output logic [31:0]       DMI_Load_Data,
  output logic              DMI_Misaligned,
  output logic              DMI_Mem_En,
  output logic [3:0]        DMI_Mem_We,
  output logic [ADDR_W-1:0] DMI_Mem_Addr,
  output logic [31:0]       DMI_Mem_WData,
  input  logic [31:0]       DMI_Mem_RData
);

  typedef enum logic [1:0] {IDLE, READ, RESP, HOLD} state_t;

  localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

  state_t      state, state_nxt;
  logic [1:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  a_q;
  logic        err_q, ld_q;
  logic        accept, illegal, mem_en, load_done;
  logic [3:0]  mem_we, we_store;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;
  logic [31:0] rd_ext;
  logic        unused_addr;

  assign unused_addr = ^DMI_Address[31:ADDR_W+2];

  assign illegal = (DMI_Funct3 == 3'b011) || (DMI_Funct3 == 3'b110) || (DMI_Funct3 == 3'b111) ||
                   ((DMI_Funct3[1:0] == 2'b01) && DMI_Address[0]) ||
                   ((DMI_Funct3 == 3'b010) && (DMI_Address[1:0] != 2'b00));

  always_comb begin
    we_store      = 4'b1111;
    DMI_Mem_WData = DMI_Store_Data;
    case (DMI_Funct3[1:0])
      2'b00: begin
        we_store      = 4'b0001 << DMI_Address[1:0];
        DMI_Mem_WData = {4{DMI_Store_Data[7:0]}};
      end
      2'b01: begin
        we_store      = 4'b0011 << {DMI_Address[1], 1'b0};
        DMI_Mem_WData = {2{DMI_Store_Data[15:0]}};
      end
      default: ;
    endcase
  end

  assign DMI_Mem_Addr = DMI_Address[ADDR_W+1:2];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    case (state)
      IDLE: if (DMI_Load_Req || DMI_Store_Req) begin
        accept = 1'b1;
        if (illegal) state_nxt = RESP;
        else if (DMI_Load_Req) begin
          state_nxt = READ;
          mem_en    = 1'b1;
        end else begin
          state_nxt = RESP;
          mem_en    = 1'b1;
          mem_we    = we_store;
        end
      end
      READ: if (cnt == 2'd0) state_nxt = RESP;
      RESP: state_nxt = HOLD;
      HOLD: if (!DMI_Load_Req && !DMI_Store_Req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Enables are combinational from the request, so keep them quiet while reset is held.
  assign DMI_Mem_En = mem_en & DMI_Reset;
  assign DMI_Mem_We = mem_we & {4{DMI_Reset}};

  assign rd_b = DMI_Mem_RData[{a_q, 3'b000} +: 8];
  assign rd_h = a_q[1] ? DMI_Mem_RData[31:16] : DMI_Mem_RData[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  rd_ext = {{24{rd_b[7]}}, rd_b};
      3'b100:  rd_ext = {24'd0, rd_b};
      3'b001:  rd_ext = {{16{rd_h[15]}}, rd_h};
      3'b101:  rd_ext = {16'd0, rd_h};
      default: rd_ext = DMI_Mem_RData;
    endcase
  end

  assign load_done = (state == READ) && (cnt == 2'd0);

  always_ff @(posedge DMI_Clk or negedge DMI_Reset) begin
    if (!DMI_Reset) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      f3_q          <= 3'd0;
      a_q           <= 2'd0;
      err_q         <= 1'b0;
      ld_q          <= 1'b0;
      DMI_Load_Data <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        f3_q  <= DMI_Funct3;
        a_q   <= DMI_Address[1:0];
        err_q <= illegal;
        ld_q  <= DMI_Load_Req;
        cnt   <= CNT_INIT;
        // A rejected load still completes, with a zero result.
        if (illegal && DMI_Load_Req) DMI_Load_Data <= 32'd0;
      end else if (state == READ) begin
        if (cnt != 2'd0) cnt <= cnt - 2'd1;
        if (load_done) DMI_Load_Data <= rd_ext;
      end
    end
  end

  assign DMI_Load_Valid  = (state == RESP) &&  ld_q;
  assign DMI_Store_Ready = (state == RESP) && !ld_q;
  assign DMI_Misaligned  = (state == RESP) &&  err_q;

endmodule

// File: tb/tb_data_mem_if.sv
// Directed bench for data_mem_if: one instance at latency 1, one at latency 3,
// sharing the request inputs.
module tb_data_mem_if;
  logic        clk = 1'b0;
  logic        rst_n, ld, st;
  logic [2:0]  f3;
  logic [31:0] addr, sd, rd1, rd3;
  logic        lv1, sr1, mis1, en1, lv3, sr3, mis3, en3;
  logic [3:0]  we1, we3;
  logic [9:0]  ma1, ma3;
  logic [31:0] wd1, wd3, ldd1, ldd3;
  int tests = 0, errs = 0;

  always #5 clk = ~clk;

  data_mem_if #(.ADDR_W(10), .MEM_LATENCY(1)) dut1 (
    .DMI_Clk(clk), .DMI_Reset(rst_n), .DMI_Load_Req(ld), .DMI_Store_Req(st),
    .DMI_Funct3(f3), .DMI_Address(addr), .DMI_Store_Data(sd),
    .DMI_Load_Valid(lv1), .DMI_Store_Ready(sr1), .DMI_Load_Data(ldd1),
    .DMI_Misaligned(mis1), .DMI_Mem_En(en1), .DMI_Mem_We(we1),
    .DMI_Mem_Addr(ma1), .DMI_Mem_WData(wd1), .DMI_Mem_RData(rd1));

  data_mem_if #(.ADDR_W(10), .MEM_LATENCY(3)) dut3 (
    .DMI_Clk(clk), .DMI_Reset(rst_n), .DMI_Load_Req(ld), .DMI_Store_Req(st),
    .DMI_Funct3(f3), .DMI_Address(addr), .DMI_Store_Data(sd),
    .DMI_Load_Valid(lv3), .DMI_Store_Ready(sr3), .DMI_Load_Data(ldd3),
    .DMI_Misaligned(mis3), .DMI_Mem_En(en3), .DMI_Mem_We(we3),
    .DMI_Mem_Addr(ma3), .DMI_Mem_WData(wd3), .DMI_Mem_RData(rd3));

  task automatic pad(input int n);
    ld = 1'b0; st = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ld = 1'b1; st = 1'b0; f3 = 3'b010; addr = 32'd0; sd = 32'd0;
    rd1 = 32'd0; rd3 = 32'd0;
    repeat (2) @(negedge clk);
    tests++; if ({lv1, sr1, mis1, lv3, sr3, mis3} !== 6'd0) begin errs++;
      $display("FAIL reset_pulses: got %b want 000000", {lv1, sr1, mis1, lv3, sr3, mis3}); end
    tests++; if ({en1, en3} !== 2'b00) begin errs++;
      $display("FAIL reset_en: got %b want 00", {en1, en3}); end
    tests++; if ({we1, we3} !== 8'd0) begin errs++;
      $display("FAIL reset_we: got %h want 00", {we1, we3}); end
    tests++; if (ldd1 !== 32'd0 || ldd3 !== 32'd0) begin errs++;
      $display("FAIL reset_ldata: got %h/%h want 0/0", ldd1, ldd3); end
    ld = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic misal(input string nm, input logic is_ld, input logic [2:0] f, input logic [31:0] a);
    pad(4);
    ld = is_ld; st = ~is_ld; f3 = f; addr = a; sd = 32'hFFFF_FFFF;
    @(negedge clk);
    tests++; if ({en1, we1} !== 5'd0) begin errs++;
      $display("FAIL %s_c0_en: got en=%b we=%b want 0/0000", nm, en1, we1); end
    @(negedge clk);
    tests++; if ({lv1, sr1, mis1} !== {is_ld, ~is_ld, 1'b1}) begin errs++;
      $display("FAIL %s_c1_resp: got lv/sr/mis=%b want %b", nm, {lv1, sr1, mis1}, {is_ld, ~is_ld, 1'b1}); end
    if (is_ld) begin
      tests++; if (ldd1 !== 32'd0) begin errs++;
        $display("FAIL %s_c1_data: got %h want 00000000", nm, ldd1); end
    end
    ld = 1'b0; st = 1'b0;
    @(negedge clk);
    tests++; if ({lv1, sr1, mis1, en1} !== 4'd0) begin errs++;
      $display("FAIL %s_c2_quiet: got %b want 0000", nm, {lv1, sr1, mis1, en1}); end
  endtask

  task automatic test_misaligned;
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk) #2 rst_n = 1'b1;
    misal("lw_a1", 1'b1, 3'b010, 32'h0000_0001);
    misal("lh_a3", 1'b1, 3'b001, 32'h0000_0003);
    misal("f3_3",  1'b1, 3'b011, 32'h0000_0000);
    misal("sw_a2", 1'b0, 3'b010, 32'h0000_0002);
  endtask

  task automatic do_load(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] rdv, input logic [31:0] exp, input int hold);
    pad(4);
    ld = 1'b1; f3 = f; addr = a; rd1 = rdv;
    @(negedge clk);
    tests++; if (en1 !== 1'b1 || we1 !== 4'd0 || ma1 !== a[11:2]) begin errs++;
      $display("FAIL %s_c0: got en=%b we=%b maddr=%h want 1/0000/%h", nm, en1, we1, ma1, a[11:2]); end
    @(negedge clk);
    tests++; if (lv1 !== 1'b0) begin errs++;
      $display("FAIL %s_c1_lv: got %b want 0", nm, lv1); end
    @(negedge clk);
    tests++; if (lv1 !== 1'b1 || mis1 !== 1'b0) begin errs++;
      $display("FAIL %s_c2_lv: got lv=%b mis=%b want 1/0", nm, lv1, mis1); end
    tests++; if (ldd1 !== exp) begin errs++;
      $display("FAIL %s_c2_data: got %h want %h", nm, ldd1, exp); end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      tests++; if ({lv1, en1, sr1} !== 3'd0) begin errs++;
        $display("FAIL %s_hold%0d: got lv/en/sr=%b want 000", nm, i, {lv1, en1, sr1}); end
    end
    ld = 1'b0;
  endtask

  task automatic test_lw;
    do_load("lw", 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3);
  endtask

  task automatic test_lb_lbu;
    do_load("lb",  3'b000, 32'h0000_0003, 32'h8012_3456, 32'hFFFF_FF80, 1);
    do_load("lbu", 3'b100, 32'h0000_0003, 32'h8012_3456, 32'h0000_0080, 1);
    do_load("lh",  3'b001, 32'h0000_0002, 32'h8012_3456, 32'hFFFF_8012, 1);
    do_load("lhu", 3'b101, 32'h0000_0000, 32'h8012_3456, 32'h0000_3456, 1);
  endtask

  task automatic do_store(input string nm, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] we_e, input logic [31:0] wd_e);
    pad(4);
    st = 1'b1; f3 = f; addr = a; sd = d;
    @(negedge clk);
    tests++; if (en1 !== 1'b1 || we1 !== we_e) begin errs++;
      $display("FAIL %s_c0_we: got en=%b we=%b want 1/%b", nm, en1, we1, we_e); end
    tests++; if (wd1 !== wd_e || ma1 !== a[11:2]) begin errs++;
      $display("FAIL %s_c0_data: got wd=%h maddr=%h want %h/%h", nm, wd1, ma1, wd_e, a[11:2]); end
    @(negedge clk);
    tests++; if ({sr1, lv1, mis1, en1} !== 4'b1000) begin errs++;
      $display("FAIL %s_c1_ready: got sr/lv/mis/en=%b want 1000", nm, {sr1, lv1, mis1, en1}); end
    st = 1'b0;
    @(negedge clk);
    tests++; if (sr1 !== 1'b0) begin errs++;
      $display("FAIL %s_c2_sr: got %b want 0", nm, sr1); end
  endtask

  task automatic test_store;
    do_store("sh", 3'b001, 32'h0000_0006, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    do_store("sb", 3'b000, 32'h0000_0011, 32'h0000_00EF, 4'b0010, 32'hEFEF_EFEF);
    do_store("sw", 3'b010, 32'h0000_0FFC, 32'h1234_5678, 4'b1111, 32'h1234_5678);
  endtask

  task automatic test_lat3_both;
    pad(6);
    ld = 1'b1; st = 1'b1; f3 = 3'b010; addr = 32'h0000_0010; rd3 = 32'hCAFE_F00D;
    @(negedge clk);
    tests++; if (en3 !== 1'b1 || we3 !== 4'd0 || ma3 !== 10'd4) begin errs++;
      $display("FAIL both_c0: got en=%b we=%b maddr=%h want 1/0000/004", en3, we3, ma3); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      tests++; if ({lv3, sr3} !== 2'b00) begin errs++;
        $display("FAIL both_c%0d_early: got lv/sr=%b want 00", i, {lv3, sr3}); end
    end
    @(negedge clk);
    tests++; if (lv3 !== 1'b1 || sr3 !== 1'b0 || ldd3 !== 32'hCAFE_F00D) begin errs++;
      $display("FAIL both_c4: got lv=%b sr=%b data=%h want 1/0/cafef00d", lv3, sr3, ldd3); end
    for (int i = 5; i <= 7; i++) begin
      @(negedge clk);
      tests++; if ({lv3, sr3, en3} !== 3'd0) begin errs++;
        $display("FAIL both_c%0d_hold: got lv/sr/en=%b want 000", i, {lv3, sr3, en3}); end
    end
    ld = 1'b0;
    for (int i = 8; i <= 9; i++) begin
      @(negedge clk);
      tests++; if ({sr3, en3} !== 2'b00) begin errs++;
        $display("FAIL both_c%0d_st_only: got sr/en=%b want 00", i, {sr3, en3}); end
    end
    st = 1'b0;
    @(posedge clk); #1;
    st = 1'b1; addr = 32'h0000_0000; sd = 32'h0BAD_CAFE;
    @(negedge clk);
    tests++; if (en3 !== 1'b1 || we3 !== 4'b1111) begin errs++;
      $display("FAIL both_next_accept: got en=%b we=%b want 1/1111", en3, we3); end
    @(negedge clk);
    tests++; if (sr3 !== 1'b1) begin errs++;
      $display("FAIL both_next_ready: got %b want 1", sr3); end
    st = 1'b0;
  endtask

  task automatic test_reset_mid;
    pad(6);
    ld = 1'b1; f3 = 3'b010; addr = 32'h0000_0020; rd3 = 32'h1122_3344;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({lv3, sr3, mis3, en3, we3} !== 8'd0) begin errs++;
      $display("FAIL rmid_outs: got %b want 00000000", {lv3, sr3, mis3, en3, we3}); end
    tests++; if (ldd3 !== 32'd0) begin errs++;
      $display("FAIL rmid_ldata: got %h want 00000000", ldd3); end
    ld = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (lv3 !== 1'b0) begin errs++;
        $display("FAIL rmid_stale_lv%0d: got %b want 0", i, lv3); end
    end
    pad(1);
    ld = 1'b1; addr = 32'h0000_0024; rd3 = 32'h5566_7788;
    @(negedge clk);
    tests++; if (en3 !== 1'b1 || ma3 !== 10'd9) begin errs++;
      $display("FAIL rmid_new_c0: got en=%b maddr=%h want 1/009", en3, ma3); end
    repeat (3) @(negedge clk);
    tests++; if (lv3 !== 1'b0) begin errs++;
      $display("FAIL rmid_new_c3: got lv=%b want 0", lv3); end
    @(negedge clk);
    tests++; if (lv3 !== 1'b1 || ldd3 !== 32'h5566_7788) begin errs++;
      $display("FAIL rmid_new_c4: got lv=%b data=%h want 1/55667788", lv3, ldd3); end
    ld = 1'b0;
    @(negedge clk);
    tests++; if (lv3 !== 1'b0) begin errs++;
      $display("FAIL rmid_new_c5: got lv=%b want 0", lv3); end
  endtask

  initial begin
    test_reset();
    test_misaligned();
    test_lw();
    test_lb_lbu();
    test_store();
    test_lat3_both();
    test_reset_mid();
    pad(3);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
